// File: rtl/mux_logic_pkg.sv
// Shared types and constants for the mux-built logic pipeline.
package mux_logic_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_XNOR = 2'd3
    } op_t;

    localparam int unsigned MUX_LOGIC_LAT = 2;
    localparam int unsigned CNT_W         = 16;

endpackage

// File: rtl/mux2.sv
// Primitive 2:1 multiplexer cell; the only logic element the gate network is built from.
module mux2 (
    input  logic sel_i,
    input  logic d0_i,
    input  logic d1_i,
    output logic y_o
);

    assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/mux_gate2.sv
// One-bit AND/OR/XOR/XNOR gate built only from 2:1 mux cells and constants.
module mux_gate2
    import mux_logic_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  op_t  op_i,
    output logic y_o
);

    logic [1:0] op_bits;
    logic       not_a;
    logic       and_y;
    logic       or_y;
    logic       xor_y;
    logic       xnor_y;
    logic       sel_lo;
    logic       sel_hi;

    assign op_bits = op_i;

    // Inverter as a mux: a ? 0 : 1.
    mux2 u_not (.sel_i(a_i), .d0_i(1'b1), .d1_i(1'b0), .y_o(not_a));

    // Every gate selects on b.
    mux2 u_and  (.sel_i(b_i), .d0_i(1'b0),  .d1_i(a_i),   .y_o(and_y));
    mux2 u_or   (.sel_i(b_i), .d0_i(a_i),   .d1_i(1'b1),  .y_o(or_y));
    mux2 u_xor  (.sel_i(b_i), .d0_i(a_i),   .d1_i(not_a), .y_o(xor_y));
    mux2 u_xnor (.sel_i(b_i), .d0_i(not_a), .d1_i(a_i),   .y_o(xnor_y));

    // 4:1 op select from three 2:1 cells.
    mux2 u_sel_lo (.sel_i(op_bits[0]), .d0_i(and_y),  .d1_i(or_y),   .y_o(sel_lo));
    mux2 u_sel_hi (.sel_i(op_bits[0]), .d0_i(xor_y),  .d1_i(xnor_y), .y_o(sel_hi));
    mux2 u_sel    (.sel_i(op_bits[1]), .d0_i(sel_lo), .d1_i(sel_hi), .y_o(y_o));

endmodule

// File: rtl/mux_xor_level.sv
// One level of the parity tree: pairs are XORed, an odd trailing bit passes straight through.
module mux_xor_level
    import mux_logic_pkg::*;
#(
    parameter int unsigned NIn = 2
) (
    input  logic [NIn-1:0]       d_i,
    output logic [(NIn+1)/2-1:0] q_o
);

    localparam int unsigned NOut = (NIn + 1) / 2;

    for (genvar j = 0; j < NOut; j++) begin : g_pair
        if (2 * j + 1 < NIn) begin : g_gate
            mux_gate2 u_xor (
                .a_i (d_i[2*j]),
                .b_i (d_i[2*j+1]),
                .op_i(OP_XOR),
                .y_o (q_o[j])
            );
        end else begin : g_pass
            assign q_o[j] = d_i[2*j];
        end
    end

endmodule

// File: rtl/mux_logic_pipe.sv
// Two-stage valid/ready pipelined W-bit logic unit with parity, built from 2:1 mux cells.
// Define MUX_LOGIC_PIPE_CNT_EN to add the saturating accepted-transaction counter out_cnt.
module mux_logic_pipe
    import mux_logic_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_res,
    output logic             out_par
`ifdef MUX_LOGIC_PIPE_CNT_EN
    ,
    output logic [CNT_W-1:0] out_cnt
`endif
);

    // Widths of each parity-tree level; six halvings cover W up to 64.
    localparam int unsigned N1 = (W + 1) / 2;
    localparam int unsigned N2 = (N1 + 1) / 2;
    localparam int unsigned N3 = (N2 + 1) / 2;
    localparam int unsigned N4 = (N3 + 1) / 2;
    localparam int unsigned N5 = (N4 + 1) / 2;
    localparam int unsigned N6 = (N5 + 1) / 2;

    op_t          op_sel;
    logic         s1_adv;
    logic         s2_adv;
    logic         accept;
    logic [W-1:0] s1_res_d;
    logic [W-1:0] s1_res_q;
    logic         s1_valid_q;
    logic         s2_valid_q;
    logic [W-1:0] s2_res_q;
    logic         s2_par_q;
    logic         s1_par;

    logic [N1-1:0] par_l1;
    logic [N2-1:0] par_l2;
    logic [N3-1:0] par_l3;
    logic [N4-1:0] par_l4;
    logic [N5-1:0] par_l5;
    logic [N6-1:0] par_l6;

    assign op_sel = op_t'(in_op);

    // Handshake: readiness propagates backwards combinationally, no skid buffer.
    assign s2_adv    = !s2_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = s1_adv;
    assign accept    = in_valid && s1_adv;
    assign out_valid = s2_valid_q;
    assign out_res   = s2_res_q;
    assign out_par   = s2_par_q;

    for (genvar i = 0; i < W; i++) begin : g_s1
        mux_gate2 u_gate (
            .a_i (in_a[i]),
            .b_i (in_b[i]),
            .op_i(op_sel),
            .y_o (s1_res_d[i])
        );
    end

    mux_xor_level #(.NIn(W))  u_par_l1 (.d_i(s1_res_q), .q_o(par_l1));
    mux_xor_level #(.NIn(N1)) u_par_l2 (.d_i(par_l1),   .q_o(par_l2));
    mux_xor_level #(.NIn(N2)) u_par_l3 (.d_i(par_l2),   .q_o(par_l3));
    mux_xor_level #(.NIn(N3)) u_par_l4 (.d_i(par_l3),   .q_o(par_l4));
    mux_xor_level #(.NIn(N4)) u_par_l5 (.d_i(par_l4),   .q_o(par_l5));
    mux_xor_level #(.NIn(N5)) u_par_l6 (.d_i(par_l5),   .q_o(par_l6));

    assign s1_par = par_l6[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_res_q   <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_res_q <= s1_res_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_par_q   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_res_q <= s1_res_q;
                s2_par_q <= s1_par;
            end
        end
    end

`ifdef MUX_LOGIC_PIPE_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturates rather than wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_cnt = cnt_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_mux_logic_pipe.sv
// Directed, table-driven bench for mux_logic_pipe (W=8 instance plus an exhaustive W=1 instance).
module tb_mux_logic_pipe;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, out_par;
    logic [W-1:0] in_a, in_b, out_res;
    logic [1:0]   in_op;

    logic         w1_in_valid, w1_in_ready, w1_out_valid, w1_out_ready, w1_out_par;
    logic [0:0]   w1_in_a, w1_in_b, w1_out_res;
    logic [1:0]   w1_in_op;

`ifdef MUX_LOGIC_PIPE_CNT_EN
    logic [15:0]  out_cnt, w1_out_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] res;
        logic       par;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    mux_logic_pipe #(.W(W)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_op    (in_op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_res  (out_res),
        .out_par  (out_par)
`ifdef MUX_LOGIC_PIPE_CNT_EN
        ,
        .out_cnt  (out_cnt)
`endif
    );

    mux_logic_pipe #(.W(1)) u_dut_w1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (w1_in_valid),
        .in_ready (w1_in_ready),
        .in_a     (w1_in_a),
        .in_b     (w1_in_b),
        .in_op    (w1_in_op),
        .out_valid(w1_out_valid),
        .out_ready(w1_out_ready),
        .out_res  (w1_out_res),
        .out_par  (w1_out_par)
`ifdef MUX_LOGIC_PIPE_CNT_EN
        ,
        .out_cnt  (w1_out_cnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_op    = op;
    endtask

    function automatic logic ref_gate(input logic a, input logic b, input logic [1:0] op);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    task automatic chk_cnt(input string name, input logic [15:0] exp);
`ifdef MUX_LOGIC_PIPE_CNT_EN
        chk(name, 64'(out_cnt), 64'(exp));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{8'hA5, 8'h3C, 2'd0, 8'h24, 1'b0};
        vecs[1]  = '{8'hA5, 8'h3C, 2'd1, 8'hBD, 1'b0};
        vecs[2]  = '{8'hA5, 8'h3C, 2'd2, 8'h99, 1'b0};
        vecs[3]  = '{8'hA5, 8'h3C, 2'd3, 8'h66, 1'b0};
        vecs[4]  = '{8'hFF, 8'h0F, 2'd0, 8'h0F, 1'b0};
        vecs[5]  = '{8'h00, 8'h01, 2'd1, 8'h01, 1'b1};
        vecs[6]  = '{8'h55, 8'hAA, 2'd2, 8'hFF, 1'b0};
        vecs[7]  = '{8'h00, 8'h00, 2'd3, 8'hFF, 1'b0};
        vecs[8]  = '{8'h13, 8'h00, 2'd2, 8'h13, 1'b1};
        vecs[9]  = '{8'h80, 8'hFF, 2'd0, 8'h80, 1'b1};
        vecs[10] = '{8'h0F, 8'h3C, 2'd3, 8'hCC, 1'b0};

        rst = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 2'd0);
        out_ready    = 1'b1;
        w1_in_valid  = 1'b0;
        w1_in_a      = 1'b0;
        w1_in_b      = 1'b0;
        w1_in_op     = 2'd0;
        w1_out_ready = 1'b1;
        tick;
        tick;
        rst = 1'b0;

        // Reset state
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_res", 64'(out_res), 64'd0);
        chk("rst out_par", 64'(out_par), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst w1 out_valid", 64'(w1_out_valid), 64'd0);
        chk_cnt("rst out_cnt", 16'd0);

        // Single transaction, latency exactly two
        drive(1'b1, 8'hF0, 8'h01, 2'd2);
        tick;
        drive(1'b0, 8'h00, 8'h00, 2'd0);
        chk("t1 lat1 out_valid", 64'(out_valid), 64'd0);
        tick;
        chk("t1 out_valid", 64'(out_valid), 64'd1);
        chk("t1 out_res", 64'(out_res), 64'hF1);
        chk("t1 out_par", 64'(out_par), 64'd1);
        tick;
        chk("t1 drained", 64'(out_valid), 64'd0);

        // Back-to-back table vectors, one per cycle
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) begin
                drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
                #1;
                chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'd1);
            end else begin
                drive(1'b0, 8'h00, 8'h00, 2'd0);
            end
            tick;
            if (i >= 1) begin
                chk($sformatf("vec%0d out_valid", i - 1), 64'(out_valid), 64'd1);
                chk($sformatf("vec%0d out_res", i - 1), 64'(out_res), 64'(vecs[i-1].res));
                chk($sformatf("vec%0d out_par", i - 1), 64'(out_par), 64'(vecs[i-1].par));
            end
        end
        tick;
        chk("vec drained", 64'(out_valid), 64'd0);
        chk_cnt("vec out_cnt", 16'd12);

        // Backpressure: third offer must stall while both stages hold data
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 8'h22, 2'd2);
        #1;
        chk("bp acc1 in_ready", 64'(in_ready), 64'd1);
        tick;
        drive(1'b1, 8'h0F, 8'hF0, 2'd2);
        #1;
        chk("bp acc2 in_ready", 64'(in_ready), 64'd1);
        tick;
        drive(1'b1, 8'h80, 8'h01, 2'd2);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp hold%0d in_ready", k), 64'(in_ready), 64'd0);
            chk($sformatf("bp hold%0d out_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("bp hold%0d out_res", k), 64'(out_res), 64'h33);
            tick;
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 64'(in_ready), 64'd1);
        tick;
        drive(1'b0, 8'h00, 8'h00, 2'd0);
        chk("bp r2 out_valid", 64'(out_valid), 64'd1);
        chk("bp r2 out_res", 64'(out_res), 64'hFF);
        tick;
        chk("bp r3 out_valid", 64'(out_valid), 64'd1);
        chk("bp r3 out_res", 64'(out_res), 64'h81);
        tick;
        chk("bp drained", 64'(out_valid), 64'd0);
        chk_cnt("bp out_cnt", 16'd15);

        // Simultaneous drain and accept with both stages full
        out_ready = 1'b0;
        drive(1'b1, 8'hC3, 8'h0F, 2'd0);
        tick;
        drive(1'b1, 8'hF0, 8'h3C, 2'd0);
        tick;
        chk("sim full out_res", 64'(out_res), 64'h03);
        out_ready = 1'b1;
        drive(1'b1, 8'h01, 8'h06, 2'd1);
        #1;
        chk("sim in_ready", 64'(in_ready), 64'd1);
        tick;
        drive(1'b0, 8'h00, 8'h00, 2'd0);
        out_ready = 1'b0;
        chk("sim next out_res", 64'(out_res), 64'h30);
        #1;
        chk("sim still full", 64'(in_ready), 64'd0);
        tick;
        chk("sim stall out_res", 64'(out_res), 64'h30);
        out_ready = 1'b1;
        tick;
        chk("sim y3 out_valid", 64'(out_valid), 64'd1);
        chk("sim y3 out_res", 64'(out_res), 64'h07);
        chk("sim y3 out_par", 64'(out_par), 64'd1);
        tick;
        chk("sim drained", 64'(out_valid), 64'd0);
        chk_cnt("sim out_cnt", 16'd18);

        // Reset with two transactions in flight
        out_ready = 1'b0;
        drive(1'b1, 8'hAA, 8'hFF, 2'd0);
        tick;
        drive(1'b1, 8'h55, 8'hFF, 2'd0);
        tick;
        drive(1'b0, 8'h00, 8'h00, 2'd0);
        chk("mrst pre out_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        out_ready = 1'b1;
        chk("mrst out_valid", 64'(out_valid), 64'd0);
        chk_cnt("mrst out_cnt", 16'd0);
        for (int k = 0; k < 3; k++) begin
            tick;
            chk($sformatf("mrst idle%0d out_valid", k), 64'(out_valid), 64'd0);
        end

        // Exhaustive W=1 instance
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                w1_in_valid = 1'b1;
                w1_in_a     = 1'(i);
                w1_in_b     = 1'(i >> 1);
                w1_in_op    = 2'(i >> 2);
            end else begin
                w1_in_valid = 1'b0;
            end
            tick;
            if (i >= 1) begin
                logic e;
                e = ref_gate(1'((i - 1)), 1'((i - 1) >> 1), 2'((i - 1) >> 2));
                chk($sformatf("w1 c%0d out_valid", i - 1), 64'(w1_out_valid), 64'd1);
                chk($sformatf("w1 c%0d out_res", i - 1), 64'(w1_out_res), 64'(e));
                chk($sformatf("w1 c%0d out_par", i - 1), 64'(w1_out_par), 64'(e));
            end
        end
        tick;
        chk("w1 drained", 64'(w1_out_valid), 64'd0);
`ifdef MUX_LOGIC_PIPE_CNT_EN
        chk("w1 out_cnt", 64'(w1_out_cnt), 64'd16);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mux_logic_pipe.md
Name: mux_logic_pipe

Overview:
- Parametrised, pipelined W-bit two-operand logic unit in which every gate is built from 2:1 mux cells and constants 0/1.
- Operation is runtime-selectable: AND, OR, XOR or XNOR.
- Also produces the XOR-reduction (parity) of the result through a mux-built tree.
- Two register stages with valid/ready handshake; a drop-in streaming successor to the single-bit mux-built gates in the day-1 exercises.

Parameters:
W, 8, operand/result width in bits; legal range 1..64.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream offers a transaction
in_ready  output  1  block accepts a transaction this cycle
in_a  input  W  operand A
in_b  input  W  operand B
in_op  input  2  operation: 0 AND, 1 OR, 2 XOR, 3 XNOR
out_valid  output  1  result available
out_ready  input  1  downstream consumes the result
out_res  output  W  bitwise result
out_par  output  1  XOR of all bits of out_res
out_cnt  output  16  accepted-transaction count; present only with MUX_LOGIC_PIPE_CNT_EN

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high (rst). rst is sampled only on the rising edge of clk.
- Reset values:
  - s1_valid = 0, s2_valid = 0.
  - out_valid = 0, out_res = 0, out_par = 0, out_cnt = 0.
  - in_ready is 1 in the cycle after reset.
- Stage 1:
  - Accept when in_valid && in_ready.
  - Register the W-bit bitwise result of in_a op in_b and set s1_valid.
- Stage 2:
  - Register stage-1 result into out_res.
  - Register the parity of the stage-1 result into out_par (mux-tree reduction, ceil(log2 W) levels, combinational inside the stage).
- Latency: exactly 2 cycles from acceptance to out_valid when there is no backpressure. Throughput is 1 transaction per cycle.
- Handshake rules:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational back-propagation; no skid buffer)
  - out_valid = s2_valid.
  - Stage registers load only when their adv term is 1; otherwise they hold.
  - Outputs are stable while out_valid && !out_ready.
- Occupancy: at most 2 transactions in flight. With out_ready = 0 and both stages full, in_ready = 0.
- Simultaneous accept and drain: when both stages are full and out_ready = 1, stage 2 takes stage 1 and stage 1 takes a new input in the same cycle. No bubble is inserted.
- Invalid data: a cycle with in_valid = 0 and s1_adv = 1 clears s1_valid. Data registers may keep stale values; verification checks data only when valid is high.
- Reset mid-operation: rst = 1 on any edge discards both stages regardless of handshake state. out_valid is 0 in the following cycle, and no in-flight result is emitted afterwards.
- W = 1: the parity tree degenerates, so out_par = out_res[0].
- Gate cell: all four ops are built as 2:1 muxes with sel = b.
  - AND = b ? a : 0
  - OR = b ? 1 : a
  - XOR = b ? ~a : a
  - XNOR = b ? a : ~a
  - ~a is itself the mux a ? 0 : 1.
  - The op select is a 4:1 mux built from 2:1 muxes.

Optional Feature:
MUX_LOGIC_PIPE_CNT_EN
- Defined:
  - Port out_cnt and a 16-bit counter exist.
  - The counter increments on every in_valid && in_ready and saturates at 16'hFFFF (no wrap).
  - rst clears it to 0.
- Undefined: no out_cnt port and no counter logic. All other behaviour is identical.

Decomposition:
- Package mux_logic_pkg:
  - typedef enum logic [1:0] op_t {OP_AND, OP_OR, OP_XOR, OP_XNOR}
  - localparams MUX_LOGIC_LAT = 2 and CNT_W = 16
- Sub-module mux_gate2: 1-bit a, b, op_t op -> y, built only from 2:1 mux instances and constants.
  - Instantiated W times for stage 1.
  - Instantiated W-1 times, with op = OP_XOR, for the parity tree.

Test Plan:
1. Reset then single transaction (W=8): in_a = 8'hF0, in_b = 8'h01, op = XOR, accepted at cycle 0 -> out_valid at cycle 2 with out_res = 8'hF1, out_par = 1.
2. All ops back-to-back, out_ready = 1, in_a = 8'hA5, in_b = 8'h3C -> results on consecutive cycles:
   - AND: 8'h24 / par 0
   - OR: 8'hBD / par 0
   - XOR: 8'h99 / par 0
   - XNOR: 8'h66 / par 0
3. Backpressure: stream 3 XOR transactions with out_ready = 0 -> first 2 accepted, in_ready = 0 on the 3rd. out_res is held at the first result until out_ready = 1. All 3 results then emerge in order with no loss or duplication.
4. Simultaneous drain and accept: both stages full, out_ready = 1, in_valid = 1 -> in_ready = 1 that cycle; occupancy stays 2; next result appears the next cycle.
5. Reset mid-operation: 2 transactions in flight, rst pulsed 1 cycle -> out_valid = 0 the next cycle and stays 0 until new input. out_cnt = 0 when MUX_LOGIC_PIPE_CNT_EN is defined.
6. Exhaustive W=1 build, all 16 (a, b, op) combinations -> out_res matches the reference gate; out_par = out_res. With MUX_LOGIC_PIPE_CNT_EN, out_cnt = 16 at the end.
